// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter sharing one add/sub datapath between two requesters.
// Single operation in flight: IDLE accepts, EXEC computes, RESP holds the result until taken.
module adder_share_arb #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic                  req0_sub_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    input  logic                  req1_sub_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_result_o,
    output logic                  rsp_carry_o,
    output logic                  rsp_zero_o,
    output logic                  rsp_overflow_o,
    output logic                  busy_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t                state_q, state_d;
    logic                  last_q, grant, acc, sub_q, id_q;
    logic                  rsp_valid_q, rsp_id_q, rsp_carry_q, rsp_zero_q, rsp_overflow_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, b_eff, rsp_result_q;
    logic [DATA_WIDTH:0]   sum;
    // A lone requester always wins; otherwise alternate away from the last winner.
    assign grant = (req0_valid_i ^ req1_valid_i) ? req1_valid_i : ~last_q;
    assign req0_ready_o = (state_q == IDLE) && !grant;
    assign req1_ready_o = (state_q == IDLE) && grant;
    assign acc = grant ? (req1_valid_i && req1_ready_o) : (req0_valid_i && req0_ready_o);
    assign b_eff = sub_q ? ~b_q : b_q;
    assign sum = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, sub_q};
    assign busy_o = state_q != IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_carry_o = rsp_carry_q;
    assign rsp_zero_o = rsp_zero_q;
    assign rsp_overflow_o = rsp_overflow_q;
    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE && acc) ? EXEC :
                  (state_q == EXEC) ? RESP :
                  (state_q == RESP && rsp_ready_i) ? IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= 1'b1;
            a_q            <= '0;
            b_q            <= '0;
            sub_q          <= 1'b0;
            id_q           <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
            rsp_zero_q     <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc) begin
                a_q    <= grant ? req1_a_i : req0_a_i;
                b_q    <= grant ? req1_b_i : req0_b_i;
                sub_q  <= grant ? req1_sub_i : req0_sub_i;
                id_q   <= grant;
                last_q <= grant;
            end
            if (state_q == EXEC) begin
                rsp_valid_q    <= 1'b1;
                rsp_id_q       <= id_q;
                rsp_result_q   <= sum[DATA_WIDTH-1:0];
                rsp_carry_q    <= sum[DATA_WIDTH];
                rsp_zero_q     <= ~|sum[DATA_WIDTH-1:0];
                rsp_overflow_q <= (a_q[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                                  (sum[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
            end else if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: scoreboard bench for the shared add/sub arbiter.
module tb_adder_share_arb;
    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req0_ready, req0_sub = 0;
    logic        req1_valid = 0, req1_ready, req1_sub = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp_valid, rsp_ready = 1, rsp_id, rsp_carry, rsp_zero, rsp_overflow, busy;
    logic [31:0] rsp_result;
    int          checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
    bit          seen = 0;
    typedef struct {
        logic        id;
        logic [31:0] res;
        logic        c, z, v;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    logic rsp_ids[$];
    int   rsp_cycs[$];

    adder_share_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_sub_i(req0_sub),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_sub_i(req1_sub),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
        .rsp_carry_o(rsp_carry), .rsp_zero_o(rsp_zero), .rsp_overflow_o(rsp_overflow), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model in signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub, input int acc);
        exp_t        e;
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      sr = sub ? sa - sb : sa + sb;
        logic [32:0] w = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        e.id  = id;
        e.res = w[31:0];
        e.c   = sub ? (a >= b) : w[32];
        e.z   = (w[31:0] == 0);
        e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            seen = 0;
        end else begin
            if (exp_q.size() == 0) check("no_spurious_rsp", rsp_valid, 0);
            else if (rsp_valid) begin
                if (!seen) begin
                    check("latency", cyc - exp_q[0].acc, 2);
                    seen = 1;
                end
                check("rsp_id", rsp_id, exp_q[0].id);
                check("rsp_result", rsp_result, exp_q[0].res);
                check("rsp_carry", rsp_carry, exp_q[0].c);
                check("rsp_zero", rsp_zero, exp_q[0].z);
                check("rsp_overflow", rsp_overflow, exp_q[0].v);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                    rsp_ids.push_back(rsp_id);
                    rsp_cycs.push_back(cyc);
                end
            end
            if (req0_valid && req0_ready) begin
                exp_q.push_back(model(0, req0_a, req0_b, req0_sub, cyc));
                acc_cnt++;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back(model(1, req1_a, req1_b, req1_sub, cyc));
                acc_cnt++;
            end
        end
    end

    task automatic wait_acc(input int start);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (acc_cnt <= start && n < 60);
        if (acc_cnt <= start) check("accept_timeout", 1, 0);
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        int start = acc_cnt;
        if (id) begin
            req1_a = a; req1_b = b; req1_sub = sub; req1_valid = 1;
        end else begin
            req0_a = a; req0_b = b; req0_sub = sub; req0_valid = 1;
        end
        wait_acc(start);
        #1;
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (exp_q.size() != 0 && n < 60);
        if (exp_q.size() != 0) check("drain_timeout", 1, 0);
        @(negedge clk);
        check("idle_after_rsp", busy, 0);
    endtask

    task automatic apply_reset();
        rst = 1;
        req0_valid = 0;
        req1_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req0_ready", req0_ready, 1);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_result", rsp_result, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        apply_reset();
        issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        drain();
        issue(1, 32'h8000_0000, 32'h0000_0001, 1);
        drain();
        issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        drain();
        issue(1, 32'h0000_1234, 32'h0000_1234, 1);
        drain();
        issue(0, 32'h0000_0005, 32'h0000_0009, 1);
        drain();
        // Contention: alternate grants starting with req0 after reset.
        apply_reset();
        rsp_ids.delete();
        rsp_cycs.delete();
        req0_a = 32'd5; req0_b = 32'd3; req0_sub = 0;
        req1_a = 32'd10; req1_b = 32'd4; req1_sub = 1;
        n = acc_cnt;
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 6; i++) wait_acc(n + i);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        drain();
        check("rr_count", rsp_ids.size(), 6);
        for (int i = 0; i < rsp_ids.size(); i++) check("rr_id", rsp_ids[i], i % 2);
        for (int i = 1; i < rsp_cycs.size(); i++) check("rr_interval", rsp_cycs[i] - rsp_cycs[i-1], 3);
        // Backpressure with req1 waiting.
        rsp_ready = 0;
        req0_a = 32'hDEAD_BEEF; req0_b = 32'h1111_1111; req0_sub = 0;
        req1_a = 32'h0000_0001; req1_b = 32'h0000_0002; req1_sub = 1;
        n = acc_cnt;
        req0_valid = 1;
        req1_valid = 1;
        wait_acc(n);
        #1 req0_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("bp_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_req1_ready", req1_ready, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req1_accept", req1_ready, 1);
        @(posedge clk);
        #1 req1_valid = 0;
        drain();
        // Reset during EXEC aborts the operation.
        issue(0, 32'h0000_00AA, 32'h0000_0055, 0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        repeat (4) @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_req0_ready", req0_ready, 1);
        check("abort_req1_ready", req1_ready, 0);
        rsp_ids.delete();
        n = acc_cnt;
        req0_a = 32'd1; req0_b = 32'd1; req0_sub = 0;
        req1_a = 32'd2; req1_b = 32'd2; req1_sub = 0;
        req0_valid = 1;
        req1_valid = 1;
        wait_acc(n);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        drain();
        check("abort_rsp_count", rsp_ids.size(), 1);
        if (rsp_ids.size() > 0) check("abort_priority_id", rsp_ids[0], 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin controller that time-shares one 32-bit add/subtract datapath between two requesters. It accepts one operation at a time through valid/ready request channels and computes it in a dedicated execute cycle. It returns the result and the carry, zero and overflow flags on a single response channel, tagged with the requester ID. It sits between the EXU-side clients (e.g. ALU path and address-generation path) and the shared adder.

## Interface
- DATA_WIDTH, 32, operand/result width; ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle when valid & ready.
- req0_a, req0_b  in  DATA_WIDTH  operands from requester 0.
- req0_sub  in  1  1 = A − B, 0 = A + B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  DATA_WIDTH  sum/difference, modulo 2^DATA_WIDTH.
- rsp_carry  out  1  carry out of MSB; for subtract, 1 = no borrow.
- rsp_zero  out  1  rsp_result == 0.
- rsp_overflow  out  1  two's-complement signed overflow.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant: if exactly one reqN_valid, grant N. If both are valid, grant the requester other than last_grant. If neither is valid, grant the requester other than last_grant.
  - reqN_ready = (state == IDLE) && (grant == N). It depends combinationally on the other requester's valid.
  - On valid & ready: latch a, b, sub and id, set last_grant = id, go to EXEC.
- EXEC:
  - Compute {carry, result} = A + (sub ? ~B : B) + sub, with a (DATA_WIDTH+1)-bit internal sum.
  - overflow = (A[MSB] == B_eff[MSB]) && (result[MSB] != A[MSB]).
  - zero = ~|result.
  - Register all of these into the rsp_* outputs, set rsp_valid = 1 and go to RESP.
- RESP:
  - rsp_* stay stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid and go to IDLE.
- No request is accepted outside IDLE, so there is exactly one operation in flight.
- Requesters must hold valid and operands stable until accepted. Valid must not depend on ready.
- Reset values: state = IDLE, last_grant = 1 (req0 wins the first contention), rsp_valid = 0, rsp_id = 0, rsp_result = 0, all flags = 0, busy = 0. req0_ready = 1 and req1_ready = 0 in the first cycle after reset.
- Reset in any state aborts the in-flight operation. No response is ever produced for it.

## Timing
- Cycle 0: IDLE, handshake on reqN.
- Cycle 1: EXEC, busy = 1, both readies low.
- Cycle 2: RESP, rsp_valid = 1 with final data.
- If rsp_ready = 1 in cycle 2, cycle 3 is IDLE and can accept a new operation. Minimum issue interval: 3 cycles. Request-to-response latency: 2 cycles.
- rsp_ready asserted before rsp_valid has no effect.
- rsp_* outputs come straight from registers. Only reqN_ready is combinational.

## Test plan
- Reset: hold rst 2 cycles with all valids low. Required: rsp_valid = 0, busy = 0, req0_ready = 1, req1_ready = 0, rsp_result = 0.
- req0 add 0xFFFFFFFF + 0x00000001, rsp_ready = 1. Required in cycle 2: rsp_valid = 1, rsp_id = 0, result = 0x00000000, carry = 1, zero = 1, overflow = 0; cycle 3 back in IDLE.
- req1 sub 0x80000000 − 0x00000001. Required: id = 1, result = 0x7FFFFFFF, carry = 1, overflow = 1, zero = 0. Then req0 add 0x7FFFFFFF + 1. Required: 0x80000000, carry = 0, overflow = 1.
- Both valids held high for 6 operations, rsp_ready = 1. Required: rsp_id sequence 0,1,0,1,0,1, one response every 3 cycles.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises, with req1_valid high throughout. Required: rsp_* unchanged, req1_ready = 0 throughout. After rsp_ready = 1, req1 is accepted in the next cycle.
- Assert rst during EXEC. Required: rsp_valid never rises for that operation; post-reset state is IDLE with req0 priority restored.
